// File: rtl/sar_search_pkg.sv
// Shared definitions for the successive-approximation search controller:
// FSM state encodings and the {aeb,agb,alb} comparator codes.
package sar_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [2:0] CMP_EQ = 3'b100;
    localparam logic [2:0] CMP_GT = 3'b010;
    localparam logic [2:0] CMP_LT = 3'b001;

    localparam int unsigned CMP_LAT_MAX = 3;

    function automatic logic cmp_is_one_hot(input logic [2:0] code);
        return (code == CMP_EQ) || (code == CMP_GT) || (code == CMP_LT);
    endfunction

endpackage

// File: rtl/sar_search_if.sv
// Request/result and comparator signals of the SAR search controller.
// The controller takes the slave side; the requester/comparator the master side.
interface sar_search_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] trial;
    logic             cmp_aeb;
    logic             cmp_agb;
    logic             cmp_alb;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             found_exact;
    logic             err;

    modport slave (
        input  start, cmp_aeb, cmp_agb, cmp_alb,
        output trial, busy, done, result, found_exact, err
    );

    modport master (
        output start, cmp_aeb, cmp_agb, cmp_alb,
        input  trial, busy, done, result, found_exact, err
    );
endinterface

// File: rtl/sar_search.sv
// Successive-approximation controller: drives the comparator B operand with
// acc|mask trials, MSB first, and converges on the largest value <= A.
module sar_search
    import sar_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int CMP_LAT    = 0,
    parameter int EARLY_EXIT = 1
) (
    input  logic         clk,
    input  logic         reset,
    sar_search_if.slave  sar
);

    localparam logic [1:0]       LAT_LOAD  = (CMP_LAT > 0) ? 2'(CMP_LAT - 1) : 2'd0;
    localparam logic [1:0]       ST_TRIAL  = (CMP_LAT > 0) ? ST_SETTLE : ST_SAMPLE;
    localparam logic [WIDTH-1:0] MASK_INIT = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mask;
    logic [1:0]       r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_found;
    logic             r_err;

    logic [2:0]       w_code;
    logic             w_one_hot;
    logic             w_keep;
    logic             w_eq;
    logic             w_exit;
    logic             w_last;
    logic [WIDTH-1:0] w_acc_sample;
    logic [WIDTH-1:0] w_mask_shift;

    // Invalid codes fall through to the alb path: the trial bit is dropped.
    assign w_code       = {sar.cmp_aeb, sar.cmp_agb, sar.cmp_alb};
    assign w_one_hot    = cmp_is_one_hot(w_code);
    assign w_eq         = (w_code == CMP_EQ);
    assign w_keep       = w_eq || (w_code == CMP_GT);
    assign w_acc_sample = w_keep ? (r_acc | r_mask) : r_acc;
    assign w_mask_shift = r_mask >> 1;
    assign w_exit       = (EARLY_EXIT != 0) && w_eq;
    assign w_last       = (w_mask_shift == '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // NOTE: default assignment first so no path through the case infers a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (sar.start) w_state_next = ST_TRIAL;
            ST_SETTLE: if (r_cnt == 2'd0) w_state_next = ST_SAMPLE;
            ST_SAMPLE: w_state_next = (w_exit || w_last) ? ST_DONE : ST_TRIAL;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc    <= '0;
            r_mask   <= '0;
            r_cnt    <= 2'd0;
            r_result <= '0;
            r_found  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (sar.start) begin
                        r_acc   <= '0;
                        r_mask  <= MASK_INIT;
                        r_cnt   <= LAT_LOAD;
                        r_found <= 1'b0;
                        r_err   <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt != 2'd0) r_cnt <= r_cnt - 2'd1;
                end
                ST_SAMPLE: begin
                    r_acc  <= w_acc_sample;
                    r_mask <= w_mask_shift;
                    r_cnt  <= LAT_LOAD;
                    if (w_eq)       r_found  <= 1'b1;
                    if (!w_one_hot) r_err    <= 1'b1;
                    if (w_exit || w_last) r_result <= w_acc_sample;
                end
                default: begin
                    r_mask <= '0;
                end
            endcase
        end
    end

    always_comb begin
        sar.trial = '0;
        sar.busy  = (r_state != ST_IDLE);
        sar.done  = (r_state == ST_DONE);
        if (r_state == ST_SETTLE || r_state == ST_SAMPLE) sar.trial = r_acc | r_mask;
    end

    assign sar.result      = r_result;
    assign sar.found_exact = r_found;
    assign sar.err         = r_err;

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search: three instances (latency/early-exit variants)
// closed around a behavioural 4-bit comparator, table vectors plus corner sequences.
module tb_sar_search;
    import sar_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [3:0] tgt     [3];
    logic       start_s [3];
    logic [3:0] trial_s [3];
    logic [3:0] result_s[3];
    logic       busy_s  [3];
    logic       done_s  [3];
    logic       found_s [3];
    logic       err_s   [3];
    logic       force0;
    logic [2:0] force_code;

    sar_search_if #(.WIDTH(4)) if0 ();
    sar_search_if #(.WIDTH(4)) if1 ();
    sar_search_if #(.WIDTH(4)) if2 ();

    // 0: no latency, early exit; 1: no latency, full run; 2: CMP_LAT=2, early exit
    sar_search #(.WIDTH(4), .CMP_LAT(0), .EARLY_EXIT(1)) u_dut0 (.clk(clk), .reset(reset), .sar(if0));
    sar_search #(.WIDTH(4), .CMP_LAT(0), .EARLY_EXIT(0)) u_dut1 (.clk(clk), .reset(reset), .sar(if1));
    sar_search #(.WIDTH(4), .CMP_LAT(2), .EARLY_EXIT(1)) u_dut2 (.clk(clk), .reset(reset), .sar(if2));

    function automatic logic [2:0] cmp3(input logic [3:0] a, input logic [3:0] b);
        return {a == b, a > b, a < b};
    endfunction

    assign {if0.cmp_aeb, if0.cmp_agb, if0.cmp_alb} = force0 ? force_code : cmp3(tgt[0], if0.trial);
    assign {if1.cmp_aeb, if1.cmp_agb, if1.cmp_alb} = cmp3(tgt[1], if1.trial);
    assign {if2.cmp_aeb, if2.cmp_agb, if2.cmp_alb} = cmp3(tgt[2], if2.trial);

    assign if0.start = start_s[0];
    assign if1.start = start_s[1];
    assign if2.start = start_s[2];

    assign trial_s[0]  = if0.trial;       assign trial_s[1]  = if1.trial;       assign trial_s[2]  = if2.trial;
    assign result_s[0] = if0.result;      assign result_s[1] = if1.result;      assign result_s[2] = if2.result;
    assign busy_s[0]   = if0.busy;        assign busy_s[1]   = if1.busy;        assign busy_s[2]   = if2.busy;
    assign done_s[0]   = if0.done;        assign done_s[1]   = if1.done;        assign done_s[2]   = if2.done;
    assign found_s[0]  = if0.found_exact; assign found_s[1]  = if1.found_exact; assign found_s[2]  = if2.found_exact;
    assign err_s[0]    = if0.err;         assign err_s[1]    = if1.err;         assign err_s[2]    = if2.err;

    typedef struct {
        int          dut;
        logic [3:0]  a;
        int          n;
        logic [15:0] seq;     // trials, right-aligned, earliest in the highest used nibble
        int          done_cyc;
        logic [3:0]  result;
        logic        found;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_conv(input int d, input logic [3:0] a);
        tgt[d]     = a;
        start_s[d] = 1'b1;
        tick();
        start_s[d] = 1'b0;
    endtask

    // Call in cycle 1 of a conversion; returns in the done cycle (or at the bound).
    task automatic follow_conv(input int d, output int cyc, output int n,
                               output logic [15:0] seq, output int hold);
        logic [3:0] prev;
        cyc  = 1;
        n    = 0;
        seq  = '0;
        hold = 0;
        prev = '0;
        while (!done_s[d] && cyc < 40) begin
            if (trial_s[d] != prev) begin
                seq  = {seq[11:0], trial_s[d]};
                n++;
                prev = trial_s[d];
            end
            if (n == 1) hold++;
            tick();
            cyc++;
        end
        if (!done_s[d]) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int          cyc;
        int          n;
        int          hold;
        int          done_seen;
        logic [15:0] seq;

        vecs[0] = '{0, 4'd11, 4, 16'h8CAB, 5, 4'd11, 1'b1};
        vecs[1] = '{0, 4'd8,  1, 16'h0008, 2, 4'd8,  1'b1};
        vecs[2] = '{1, 4'd8,  4, 16'h8CA9, 5, 4'd8,  1'b1};
        vecs[3] = '{0, 4'd0,  4, 16'h8421, 5, 4'd0,  1'b0};
        vecs[4] = '{0, 4'd15, 4, 16'h8CEF, 5, 4'd15, 1'b1};
        vecs[5] = '{1, 4'd15, 4, 16'h8CEF, 5, 4'd15, 1'b1};
        vecs[6] = '{1, 4'd0,  4, 16'h8421, 5, 4'd0,  1'b0};
        vecs[7] = '{0, 4'd6,  3, 16'h0846, 4, 4'd6,  1'b1};
        vecs[8] = '{1, 4'd6,  4, 16'h8467, 5, 4'd6,  1'b1};
        vecs[9] = '{0, 4'd12, 2, 16'h008C, 3, 4'd12, 1'b1};

        for (int i = 0; i < 3; i++) begin
            tgt[i]     = '0;
            start_s[i] = 1'b0;
        end
        force0     = 1'b0;
        force_code = 3'b000;
        reset      = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        check("rst_trial", 32'(trial_s[0]), 32'd0);
        check("rst_busy",  32'(busy_s[0]),  32'd0);
        check("rst_done",  32'(done_s[0]),  32'd0);
        check("rst_result", 32'(result_s[0]), 32'd0);
        check("rst_found", 32'(found_s[0]), 32'd0);
        check("rst_err",   32'(err_s[0]),   32'd0);

        for (int i = 0; i < 10; i++) begin
            start_conv(vecs[i].dut, vecs[i].a);
            check($sformatf("v%0d_busy", i), 32'(busy_s[vecs[i].dut]), 32'd1);
            follow_conv(vecs[i].dut, cyc, n, seq, hold);
            check($sformatf("v%0d_trials", i), 32'(seq), 32'(vecs[i].seq));
            check($sformatf("v%0d_ntrials", i), 32'(n), 32'(vecs[i].n));
            check($sformatf("v%0d_done_cyc", i), 32'(cyc), 32'(vecs[i].done_cyc));
            check($sformatf("v%0d_result", i), 32'(result_s[vecs[i].dut]), 32'(vecs[i].result));
            check($sformatf("v%0d_found", i), 32'(found_s[vecs[i].dut]), 32'(vecs[i].found));
            check($sformatf("v%0d_err", i), 32'(err_s[vecs[i].dut]), 32'd0);
            tick();
            check($sformatf("v%0d_idle_busy", i), 32'(busy_s[vecs[i].dut]), 32'd0);
            check($sformatf("v%0d_idle_done", i), 32'(done_s[vecs[i].dut]), 32'd0);
            check($sformatf("v%0d_hold_result", i), 32'(result_s[vecs[i].dut]), 32'(vecs[i].result));
        end

        // CMP_LAT=2: each trial held 3 cycles, done 13 cycles after start.
        start_conv(2, 4'd5);
        follow_conv(2, cyc, n, seq, hold);
        check("lat2_trials",   32'(seq),  32'h0000_8465);
        check("lat2_hold",     32'(hold), 32'd3);
        check("lat2_done_cyc", 32'(cyc),  32'd13);
        check("lat2_result",   32'(result_s[2]), 32'd5);
        check("lat2_found",    32'(found_s[2]),  32'd1);
        tick();

        // Comparator code 011 held from the 2nd sample to the end of the run.
        start_conv(0, 4'd11);
        check("bad_trial1", 32'(trial_s[0]), 32'd8);
        tick();
        check("bad_trial2", 32'(trial_s[0]), 32'd12);
        force0     = 1'b1;
        force_code = 3'b011;
        tick();
        check("bad_trial3_bit2_clear", 32'(trial_s[0]), 32'd10);
        tick();
        check("bad_trial4", 32'(trial_s[0]), 32'd9);
        tick();
        check("bad_done",   32'(done_s[0]),   32'd1);
        check("bad_result", 32'(result_s[0]), 32'd8);
        check("bad_err",    32'(err_s[0]),    32'd1);
        check("bad_found",  32'(found_s[0]),  32'd0);
        force0 = 1'b0;
        tick();
        check("bad_err_sticky", 32'(err_s[0]), 32'd1);

        start_conv(0, 4'd3);
        check("err_cleared_on_start", 32'(err_s[0]), 32'd0);
        follow_conv(0, cyc, n, seq, hold);
        check("a3_trials", 32'(seq), 32'h0000_8423);
        check("a3_result", 32'(result_s[0]), 32'd3);
        check("a3_err",    32'(err_s[0]),    32'd0);
        tick();

        // Reset during the 3rd sample aborts with no done pulse.
        start_conv(0, 4'd11);
        tick();
        tick();
        check("abort_trial3", 32'(trial_s[0]), 32'd10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_trial",  32'(trial_s[0]),  32'd0);
        check("abort_busy",   32'(busy_s[0]),   32'd0);
        check("abort_done",   32'(done_s[0]),   32'd0);
        check("abort_result", 32'(result_s[0]), 32'd0);
        check("abort_found",  32'(found_s[0]),  32'd0);
        check("abort_err",    32'(err_s[0]),    32'd0);
        done_seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (done_s[0] || busy_s[0]) done_seen++;
            tick();
        end
        check("abort_no_done", 32'(done_seen), 32'd0);

        // Start while busy and in DONE is ignored.
        start_conv(0, 4'd11);
        tick();
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        check("busy_start_trial3", 32'(trial_s[0]), 32'd10);
        tick();
        check("busy_start_trial4", 32'(trial_s[0]), 32'd11);
        tick();
        check("busy_start_done",   32'(done_s[0]),   32'd1);
        check("busy_start_result", 32'(result_s[0]), 32'd11);
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        check("done_start_idle", 32'(busy_s[0]), 32'd0);
        tick();
        check("done_start_still_idle", 32'(busy_s[0]), 32'd0);
        check("done_start_trial", 32'(trial_s[0]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
